// File: rtl/rst_pkg.sv
// Shared definitions for the reset sequencer.
//   state_t : sequencer FSM states
//   clog2   : ceiling log2 for parameter-derived widths (clog2(1) = 0)
package rst_pkg;

  typedef enum logic [2:0] {
    HOLD,
    WAIT_RDY,
    SETTLE,
    RUN,
    SHUTDOWN,
    FAULT
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (longint unsigned p = 1; p < longint'(v); p = p << 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/rst_delay_cnt.sv
// Loadable saturating down-counter used for both settle and ready-timeout
// intervals.
//   clk, reset : clock and synchronous active-high reset (loads RESET_VAL)
//   load       : load load_val this edge (takes priority over counting)
//   load_val   : value to load; done rises after load_val further edges
//   done       : count has reached zero (holds there)
module rst_delay_cnt #(
  parameter int unsigned     CW        = 5,
  parameter logic [CW-1:0]   RESET_VAL = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done
);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= RESET_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/rst_sequencer.sv
// Ordered reset release / shutdown sequencer for N_STAGES reset domains.
// Stage i is released only after stage i-1 reports ready and STAGE_DELAY
// settle edges have elapsed; a software request shuts the domains down in
// reverse order and re-sequences; a ready timeout or ready loss raises a
// sticky fault with all domains held in reset.
//   clk, reset  : clock, synchronous active-high reset
//   ready       : per-domain ready level (same clock domain)
//   sw_rst_req  : pulse, ordered shutdown then re-sequence (honoured in RUN)
//   retry       : pulse, leave FAULT and restart from HOLD
//   stage_reset : per-domain active-high reset (registered)
//   all_ready   : high only in RUN
//   fault       : sticky fault flag
//   fault_stage : index of the faulting stage (kept after retry)
module rst_sequencer
  import rst_pkg::*;
#(
  parameter  int unsigned N_STAGES    = 4,
  parameter  int unsigned STAGE_DELAY = 16,
  parameter  int unsigned TIMEOUT     = 65535,
  localparam int unsigned IW          = (N_STAGES > 1) ? clog2(N_STAGES) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_STAGES-1:0] ready,
  input  logic                sw_rst_req,
  input  logic                retry,
  output logic [N_STAGES-1:0] stage_reset,
  output logic                all_ready,
  output logic                fault,
  output logic [IW-1:0]       fault_stage
);

  localparam int unsigned   MAXD      = (STAGE_DELAY > TIMEOUT) ? STAGE_DELAY : TIMEOUT;
  localparam int unsigned   CW        = clog2(MAXD + 1);
  // Counter holds "edges remaining minus one": done is seen on the edge that
  // completes the interval, so the load value is the interval length - 1.
  localparam logic [CW-1:0] SETTLE_LD = CW'(STAGE_DELAY - 1);
  localparam logic [CW-1:0] TMO_LD    = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] LAST      = IW'(N_STAGES - 1);

  state_t        state;
  logic [IW-1:0] idx;

  logic          cnt_done;
  logic          cnt_load;
  logic [CW-1:0] cnt_val;

  logic          ev_adv;
  logic          ev_fault;
  logic [IW-1:0] fault_idx;

  logic          zero_any;
  logic [IW-1:0] zero_any_idx;
  logic          zero_upto;
  logic [IW-1:0] zero_upto_idx;

  rst_delay_cnt #(
    .CW        (CW),
    .RESET_VAL (SETTLE_LD)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  // Lowest dropped ready overall, and lowest dropped ready among stages
  // already released (j <= idx).
  always_comb begin
    zero_any      = 1'b0;
    zero_any_idx  = '0;
    zero_upto     = 1'b0;
    zero_upto_idx = '0;
    for (int unsigned j = 0; j < N_STAGES; j++) begin
      if (!ready[j]) begin
        if (!zero_any) begin
          zero_any     = 1'b1;
          zero_any_idx = IW'(j);
        end
        if (!zero_upto && (j <= 32'(idx))) begin
          zero_upto     = 1'b1;
          zero_upto_idx = IW'(j);
        end
      end
    end
  end

  // Per-state decode of fault and advance conditions. The counter is
  // reloaded on every advance: WAIT_RDY is entered from HOLD and SETTLE and
  // needs the timeout interval; every other destination needs a settle.
  always_comb begin
    ev_adv    = 1'b0;
    ev_fault  = 1'b0;
    fault_idx = idx;
    unique case (state)
      HOLD:     ev_adv = cnt_done;
      WAIT_RDY: begin
        ev_adv   = ready[idx];
        ev_fault = !ready[idx] && cnt_done;
      end
      SETTLE: begin
        ev_adv    = cnt_done;
        ev_fault  = zero_upto;
        fault_idx = zero_upto_idx;
      end
      RUN: begin
        ev_adv    = sw_rst_req;
        ev_fault  = zero_any;
        fault_idx = zero_any_idx;
      end
      SHUTDOWN: ev_adv = cnt_done;
      FAULT:    ev_adv = retry;
      default:  ev_adv = 1'b0;
    endcase
    cnt_load = ev_adv;
    cnt_val  = ((state == HOLD) || (state == SETTLE)) ? TMO_LD : SETTLE_LD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HOLD;
      idx         <= '0;
      stage_reset <= '1;
      all_ready   <= 1'b0;
      fault       <= 1'b0;
      fault_stage <= '0;
    end else if (ev_fault) begin
      state       <= FAULT;
      stage_reset <= '1;
      all_ready   <= 1'b0;
      fault       <= 1'b1;
      fault_stage <= fault_idx;
    end else if (ev_adv) begin
      unique case (state)
        HOLD: begin
          stage_reset[0] <= 1'b0;
          idx            <= '0;
          state          <= WAIT_RDY;
        end
        WAIT_RDY: begin
          if (idx == LAST) begin
            state     <= RUN;
            all_ready <= 1'b1;
          end else begin
            state <= SETTLE;
          end
        end
        SETTLE: begin
          stage_reset[idx + 1'b1] <= 1'b0;
          idx                     <= idx + 1'b1;
          state                   <= WAIT_RDY;
        end
        RUN: begin
          state             <= SHUTDOWN;
          idx               <= LAST;
          stage_reset[LAST] <= 1'b1;
          all_ready         <= 1'b0;
        end
        SHUTDOWN: begin
          // Stage 0 already reasserted: its settle is over, restart.
          if (idx == '0) begin
            state <= HOLD;
          end else begin
            idx                     <= idx - 1'b1;
            stage_reset[idx - 1'b1] <= 1'b1;
          end
        end
        FAULT: begin
          state <= HOLD;
          fault <= 1'b0;
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with N_STAGES=4, STAGE_DELAY=4, TIMEOUT=20.
module tb_rst_sequencer;

  logic       clk;
  logic       reset;
  logic [3:0] ready;
  logic       sw_rst_req;
  logic       retry;
  logic [3:0] stage_reset;
  logic       all_ready;
  logic       fault;
  logic [1:0] fault_stage;

  int checks = 0;
  int errors = 0;

  rst_sequencer #(
    .N_STAGES    (4),
    .STAGE_DELAY (4),
    .TIMEOUT     (20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ready       (ready),
    .sw_rst_req  (sw_rst_req),
    .retry       (retry),
    .stage_reset (stage_reset),
    .all_ready   (all_ready),
    .fault       (fault),
    .fault_stage (fault_stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic [3:0]  rdy;
    logic        sw;
    logic        rty;
    int unsigned n;
    logic [3:0]  sr;
    logic        ar;
    logic        f;
    logic [1:0]  fs;
  } vec_t;

  vec_t tbl[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [3:0] sr, input logic ar,
                         input logic f, input logic [1:0] fs);
    chk({nm, ".stage_reset"}, 32'(stage_reset), 32'(sr));
    chk({nm, ".all_ready"},   32'(all_ready),   32'(ar));
    chk({nm, ".fault"},       32'(fault),       32'(f));
    chk({nm, ".fault_stage"}, 32'(fault_stage), 32'(fs));
  endtask

  // Two reset edges, check reset values, then release: the next step is edge 0.
  task automatic do_reset(input string nm);
    reset = 1'b1;
    step();
    step();
    chk_all({nm, "_reset"}, 4'hF, 1'b0, 1'b0, 2'd0);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] expv;

    reset      = 1'b1;
    ready      = 4'hF;
    sw_rst_req = 1'b0;
    retry      = 1'b0;

    // Ready high before release (zero-wait), then shutdown, then a fault
    // racing a shutdown request, then retry.
    //               rst  rdy   sw rty  n  sr    ar f  fs
    tbl.push_back('{1'b1, 4'hF, 0, 0, 2, 4'hF, 0, 0, 0});
    tbl.push_back('{1'b0, 4'hF, 0, 0, 3, 4'hF, 0, 0, 0});
    tbl.push_back('{1'b0, 4'hF, 0, 0, 1, 4'hE, 0, 0, 0});
    tbl.push_back('{1'b0, 4'hF, 0, 0, 4, 4'hE, 0, 0, 0});
    tbl.push_back('{1'b0, 4'hF, 0, 0, 1, 4'hC, 0, 0, 0});
    tbl.push_back('{1'b0, 4'hF, 0, 0, 4, 4'hC, 0, 0, 0});
    tbl.push_back('{1'b0, 4'hF, 0, 0, 1, 4'h8, 0, 0, 0});
    tbl.push_back('{1'b0, 4'hF, 0, 0, 4, 4'h8, 0, 0, 0});
    tbl.push_back('{1'b0, 4'hF, 0, 0, 1, 4'h0, 0, 0, 0});
    tbl.push_back('{1'b0, 4'hF, 0, 0, 1, 4'h0, 1, 0, 0});
    tbl.push_back('{1'b0, 4'hF, 0, 0, 2, 4'h0, 1, 0, 0});
    tbl.push_back('{1'b0, 4'hF, 1, 0, 1, 4'h8, 0, 0, 0});
    tbl.push_back('{1'b0, 4'hF, 0, 0, 3, 4'h8, 0, 0, 0});
    tbl.push_back('{1'b0, 4'hF, 0, 0, 1, 4'hC, 0, 0, 0});
    tbl.push_back('{1'b0, 4'hF, 0, 0, 3, 4'hC, 0, 0, 0});
    tbl.push_back('{1'b0, 4'hF, 0, 0, 1, 4'hE, 0, 0, 0});
    tbl.push_back('{1'b0, 4'hF, 0, 0, 3, 4'hE, 0, 0, 0});
    tbl.push_back('{1'b0, 4'hF, 0, 0, 1, 4'hF, 0, 0, 0});
    tbl.push_back('{1'b0, 4'hF, 0, 0, 7, 4'hF, 0, 0, 0});
    tbl.push_back('{1'b0, 4'hF, 0, 0, 1, 4'hE, 0, 0, 0});
    tbl.push_back('{1'b0, 4'hF, 0, 0, 4, 4'hE, 0, 0, 0});
    tbl.push_back('{1'b0, 4'hF, 0, 0, 1, 4'hC, 0, 0, 0});
    tbl.push_back('{1'b0, 4'hF, 0, 0, 4, 4'hC, 0, 0, 0});
    tbl.push_back('{1'b0, 4'hF, 0, 0, 1, 4'h8, 0, 0, 0});
    tbl.push_back('{1'b0, 4'hF, 0, 0, 4, 4'h8, 0, 0, 0});
    tbl.push_back('{1'b0, 4'hF, 0, 0, 1, 4'h0, 0, 0, 0});
    tbl.push_back('{1'b0, 4'hF, 0, 0, 1, 4'h0, 1, 0, 0});
    tbl.push_back('{1'b0, 4'h5, 1, 0, 1, 4'hF, 0, 1, 1});
    tbl.push_back('{1'b0, 4'h5, 0, 0, 3, 4'hF, 0, 1, 1});
    tbl.push_back('{1'b0, 4'h5, 1, 0, 1, 4'hF, 0, 1, 1});
    tbl.push_back('{1'b0, 4'hF, 0, 1, 1, 4'hF, 0, 0, 1});
    tbl.push_back('{1'b0, 4'hF, 0, 0, 3, 4'hF, 0, 0, 1});
    tbl.push_back('{1'b0, 4'hF, 0, 0, 1, 4'hE, 0, 0, 1});

    foreach (tbl[k]) begin
      reset      = tbl[k].rst;
      ready      = tbl[k].rdy;
      sw_rst_req = tbl[k].sw;
      retry      = tbl[k].rty;
      repeat (tbl[k].n) step();
      chk_all($sformatf("vec%0d", k), tbl[k].sr, tbl[k].ar, tbl[k].f, tbl[k].fs);
    end
    sw_rst_req = 1'b0;
    retry      = 1'b0;

    // Ready raised 3 cycles after each release.
    ready = 4'h0;
    do_reset("s1");
    repeat (3) step();
    chk("s1_hold", 32'(stage_reset), 32'hF);
    step();
    chk("s1_rel0", 32'(stage_reset), 32'hE);
    for (int i = 0; i < 4; i++) begin
      expv = 4'(4'hF << (i + 1));
      repeat (3) step();
      chk($sformatf("s1_wait%0d", i), 32'({stage_reset, all_ready}), 32'({expv, 1'b0}));
      ready[i] = 1'b1;
      if (i < 3) begin
        repeat (4) step();
        chk($sformatf("s1_settle%0d", i), 32'(stage_reset), 32'(expv));
        step();
        expv = 4'(4'hF << (i + 2));
        chk($sformatf("s1_rel%0d", i + 1), 32'(stage_reset), 32'(expv));
      end else begin
        step();
        chk_all("s1_run", 4'h0, 1'b1, 1'b0, 2'd0);
      end
    end

    // Ready[2] never rises: timeout 20 edges after its release.
    ready = 4'b1011;
    do_reset("s2");
    repeat (13) step();
    chk("s2_pre2", 32'(stage_reset), 32'hC);
    step();
    chk("s2_rel2", 32'(stage_reset), 32'h8);
    repeat (19) step();
    chk_all("s2_edge19", 4'h8, 1'b0, 1'b0, 2'd0);
    step();
    chk_all("s2_timeout", 4'hF, 1'b0, 1'b1, 2'd2);
    retry = 1'b1;
    step();
    retry = 1'b0;
    chk_all("s2_retry", 4'hF, 1'b0, 1'b0, 2'd2);
    repeat (3) step();
    chk("s2_hold", 32'(stage_reset), 32'hF);
    step();
    chk("s2_rel0", 32'(stage_reset), 32'hE);

    // Reset pulse during SETTLE(1), then ready[0] loss during SETTLE(0).
    ready = 4'hF;
    do_reset("s5");
    repeat (9) step();
    chk("s5_rel1", 32'(stage_reset), 32'hC);
    step();
    step();
    chk("s5_settle1", 32'({stage_reset, fault}), 32'({4'hC, 1'b0}));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_all("s5_midreset", 4'hF, 1'b0, 1'b0, 2'd0);
    repeat (3) step();
    chk("s5_hold", 32'(stage_reset), 32'hF);
    step();
    chk("s5_rel0", 32'(stage_reset), 32'hE);
    step();
    ready[0] = 1'b0;
    step();
    chk_all("s5_drop0", 4'hF, 1'b0, 1'b1, 2'd0);

    // Ready[1] loss during SETTLE(1).
    ready = 4'hF;
    do_reset("s7");
    repeat (10) step();
    chk("s7_settle1", 32'(stage_reset), 32'hC);
    ready[1] = 1'b0;
    step();
    chk_all("s7_drop1", 4'hF, 1'b0, 1'b1, 2'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
